// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: time-multiplexed scan controller for a 4-digit
// common-anode 7-segment display. Produces a 4-bit decoder code per slot
// (4'hF = blank), active-low anodes and an active-low decimal point.
// New display contents are staged and only applied at a frame wrap, so a
// frame never shows a mix of old and new digits.
//
// Optional feature macro: SEG7_SCAN_BLINK_EN
//   When defined, a frame counter toggles a blink phase every BLINK_FRAMES
//   frames; while blink=1 and the phase is set, anodes and dp are forced off.
//   When undefined, the blink input is ignored.
module seg7_scan_ctrl #(
  parameter int REFRESH_DIV  = 100000,
  parameter int GUARD        = 4,
  parameter int BLINK_FRAMES = 128
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] digits,
  input  logic [1:0]  mode,
  input  logic [3:0]  dp_en,
  input  logic        lz_blank,
  input  logic        update,
  input  logic        blink,
  output logic        update_ack,
  output logic [3:0]  code,
  output logic [3:0]  an,
  output logic        dp
);

  typedef enum logic [1:0] {
    MODE_NUM   = 2'd0,
    MODE_ERR   = 2'd1,
    MODE_DONE  = 2'd2,
    MODE_BLANK = 2'd3
  } mode_e;

  localparam int TW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(REFRESH_DIV - 1);

  // scan position
  logic [TW-1:0] tick_q, tick_d;
  logic [1:0]    idx_q, idx_d;

  // staging (written by update) and shadow (what is being displayed)
  logic [15:0] stg_digits_q, stg_digits_d;
  mode_e       stg_mode_q, stg_mode_d;
  logic [3:0]  stg_dp_q, stg_dp_d;
  logic        stg_lz_q, stg_lz_d;
  logic        pending_q, pending_d;

  logic [15:0] shd_digits_q, shd_digits_d;
  mode_e       shd_mode_q, shd_mode_d;
  logic [3:0]  shd_dp_q, shd_dp_d;
  logic        shd_lz_q, shd_lz_d;

  // registered outputs
  logic       ack_q, ack_d;
  logic [3:0] code_q, code_d;
  logic [3:0] an_q, an_d;
  logic       dp_q, dp_d;

  logic tick_last;
  logic frame_wrap;
  logic in_guard;
  logic [3:0] cur_nib;
  logic lead3, lead2, lead1;
  logic lz_hit;
  logic [3:0] code_sel;

  assign tick_last  = (tick_q == TICK_LAST);
  assign frame_wrap = tick_last && (idx_q == 2'd3);
  assign in_guard   = (int'(tick_q) < GUARD);

  // slot timer and digit index advance
  always_comb begin
    tick_d = tick_q + TW'(1);
    idx_d  = idx_q;
    if (tick_last) begin
      tick_d = '0;
      idx_d  = idx_q + 2'd1;
    end
  end

  // update staging and frame-synchronous transfer into the shadow set
  always_comb begin
    stg_digits_d = stg_digits_q;
    stg_mode_d   = stg_mode_q;
    stg_dp_d     = stg_dp_q;
    stg_lz_d     = stg_lz_q;
    pending_d    = pending_q;
    shd_digits_d = shd_digits_q;
    shd_mode_d   = shd_mode_q;
    shd_dp_d     = shd_dp_q;
    shd_lz_d     = shd_lz_q;
    ack_d        = 1'b0;

    if (update) begin
      stg_digits_d = digits;
      stg_mode_d   = mode_e'(mode);
      stg_dp_d     = dp_en;
      stg_lz_d     = lz_blank;
      pending_d    = 1'b1;
    end

    // an update landing on the wrap itself bypasses staging
    if (frame_wrap && (pending_q || update)) begin
      if (update) begin
        shd_digits_d = digits;
        shd_mode_d   = mode_e'(mode);
        shd_dp_d     = dp_en;
        shd_lz_d     = lz_blank;
      end else begin
        shd_digits_d = stg_digits_q;
        shd_mode_d   = stg_mode_q;
        shd_dp_d     = stg_dp_q;
        shd_lz_d     = stg_lz_q;
      end
      pending_d = 1'b0;
      ack_d     = 1'b1;
    end
  end

  // code for the current slot from the shadow set
  always_comb begin
    cur_nib = shd_digits_q[{idx_q, 2'b00} +: 4];
    lead3   = (shd_digits_q[15:12] == 4'h0);
    lead2   = lead3 && (shd_digits_q[11:8] == 4'h0);
    lead1   = lead2 && (shd_digits_q[7:4] == 4'h0);
    lz_hit  = 1'b0;
    case (idx_q)
      2'd3:    lz_hit = lead3;
      2'd2:    lz_hit = lead2;
      2'd1:    lz_hit = lead1;
      default: lz_hit = 1'b0;   // digit 0 always shows
    endcase

    code_sel = 4'hF;
    case (shd_mode_q)
      MODE_NUM: code_sel = (shd_lz_q && lz_hit) ? 4'hF : cur_nib;
      MODE_ERR: begin
        case (idx_q)
          2'd3:    code_sel = 4'hF;
          2'd2:    code_sel = 4'hE;
          default: code_sel = 4'hA;
        endcase
      end
      MODE_DONE: begin
        case (idx_q)
          2'd3:    code_sel = 4'hD;
          2'd2:    code_sel = 4'hC;
          2'd1:    code_sel = 4'hB;
          default: code_sel = 4'hE;
        endcase
      end
      default: code_sel = 4'hF;
    endcase
  end

`ifdef SEG7_SCAN_BLINK_EN
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);

  logic [FW-1:0] frame_cnt_q, frame_cnt_d;
  logic          phase_q, phase_d;

  // blink phase: toggles every BLINK_FRAMES frame wraps, held clear while blink=0
  always_comb begin
    frame_cnt_d = frame_cnt_q;
    phase_d     = phase_q;
    if (!blink) begin
      frame_cnt_d = '0;
      phase_d     = 1'b0;
    end else if (frame_wrap) begin
      if (frame_cnt_q == FRAME_LAST) begin
        frame_cnt_d = '0;
        phase_d     = ~phase_q;
      end else begin
        frame_cnt_d = frame_cnt_q + FW'(1);
      end
    end
  end

  // blink phase registers
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt_q <= '0;
      phase_q     <= 1'b0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
      phase_q     <= phase_d;
    end
  end
`else
  logic blink_unused;
  assign blink_unused = blink & (BLINK_FRAMES > 0);
`endif

  // anode, dp and code for the next output register
  always_comb begin
    code_d = code_sel;
    an_d   = ~(4'b0001 << idx_q);
    dp_d   = ~shd_dp_q[idx_q];
    // blank mode keeps every anode off, not just the guard window
    if (in_guard || (shd_mode_q == MODE_BLANK)) begin
      an_d = 4'b1111;
    end
    if (in_guard || (shd_mode_q != MODE_NUM)) begin
      dp_d = 1'b1;
    end
`ifdef SEG7_SCAN_BLINK_EN
    if (blink && phase_q) begin
      an_d = 4'b1111;
      dp_d = 1'b1;
    end
`endif
  end

  // state registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      tick_q       <= '0;
      idx_q        <= 2'd0;
      stg_digits_q <= 16'h0000;
      stg_mode_q   <= MODE_BLANK;
      stg_dp_q     <= 4'h0;
      stg_lz_q     <= 1'b0;
      pending_q    <= 1'b0;
      shd_digits_q <= 16'h0000;
      shd_mode_q   <= MODE_BLANK;
      shd_dp_q     <= 4'h0;
      shd_lz_q     <= 1'b0;
      ack_q        <= 1'b0;
      code_q       <= 4'hF;
      an_q         <= 4'b1111;
      dp_q         <= 1'b1;
    end else begin
      tick_q       <= tick_d;
      idx_q        <= idx_d;
      stg_digits_q <= stg_digits_d;
      stg_mode_q   <= stg_mode_d;
      stg_dp_q     <= stg_dp_d;
      stg_lz_q     <= stg_lz_d;
      pending_q    <= pending_d;
      shd_digits_q <= shd_digits_d;
      shd_mode_q   <= shd_mode_d;
      shd_dp_q     <= shd_dp_d;
      shd_lz_q     <= shd_lz_d;
      ack_q        <= ack_d;
      code_q       <= code_d;
      an_q         <= an_d;
      dp_q         <= dp_d;
    end
  end

  assign update_ack = ack_q;
  assign code       = code_q;
  assign an         = an_q;
  assign dp         = dp_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl with REFRESH_DIV=8, GUARD=2.
// Each update pushes the frame it should produce; each ack pops it and the
// following full frame is compared slot by slot.
module tb_seg7_scan_ctrl;

  localparam int RD = 8;
  localparam int GD = 2;
  localparam int FR = 4 * RD;

  typedef struct packed {
    logic [15:0] codes;   // [15:12] = digit 3 ... [3:0] = digit 0
    logic [3:0]  dpn;     // expected active-low dp per digit outside guard
    logic        lit;     // 0 = anodes stay off all frame
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] digits = 16'h0000;
  logic [1:0]  mode = 2'd3;
  logic [3:0]  dp_en = 4'h0;
  logic        lz_blank = 1'b0;
  logic        update = 1'b0;
  logic        blink = 1'b0;
  logic        update_ack;
  logic [3:0]  code;
  logic [3:0]  an;
  logic        dp;

  int   checks = 0;
  int   errors = 0;
  int   pos = 0;
  int   ack_cnt = 0;
  exp_t sb[$];

  seg7_scan_ctrl #(.REFRESH_DIV(RD), .GUARD(GD), .BLINK_FRAMES(2)) dut (
    .clk(clk), .rst(rst), .digits(digits), .mode(mode), .dp_en(dp_en),
    .lz_blank(lz_blank), .update(update), .blink(blink),
    .update_ack(update_ack), .code(code), .an(an), .dp(dp)
  );

  always #5 clk = ~clk;

  // cycles since reset release; before edge k the DUT is at tick k%8, slot (k/8)%4
  always @(posedge clk) begin
    if (rst) pos <= 0;
    else     pos <= pos + 1;
  end

  always @(posedge clk) begin
    if (update_ack === 1'b1) ack_cnt <= ack_cnt + 1;
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  task automatic chk_blank(input string tag);
    chk({tag, "_an"}, {12'h0, an}, 16'h000F);
    chk({tag, "_code"}, {12'h0, code}, 16'h000F);
    chk({tag, "_dp"}, {15'h0, dp}, 16'h0001);
    chk({tag, "_ack"}, {15'h0, update_ack}, 16'h0000);
  endtask

  task automatic wait_pos(input int target);
    int n = 0;
    while ((pos % FR) != target && n < 2 * FR) begin
      @(negedge clk);
      n++;
    end
    if ((pos % FR) != target) begin
      errors++;
      $display("FAIL wait_pos timeout observed=%0d expected=%0d", pos % FR, target);
    end
  endtask

  task automatic do_update(input logic [15:0] d, input logic [1:0] m,
                           input logic [3:0] dpe, input logic lz,
                           input exp_t e, input bit supersede);
    if (supersede && sb.size() > 0) void'(sb.pop_back());
    sb.push_back(e);
    digits   = d;
    mode     = m;
    dp_en    = dpe;
    lz_blank = lz;
    update   = 1'b1;
    @(negedge clk);
    update   = 1'b0;
  endtask

  task automatic check_frame(input exp_t e);
    int slot;
    int t;
    int low;
    logic [3:0] on_an;
    low = 0;
    for (int j = 0; j < FR; j++) begin
      @(negedge clk);
      slot  = j / RD;
      t     = j % RD;
      on_an = ~(4'b0001 << slot);
      chk("frame_an", {12'h0, an}, {12'h0, (t < GD || !e.lit) ? 4'b1111 : on_an});
      chk("frame_code", {12'h0, code}, {12'h0, e.codes[slot*4 +: 4]});
      chk("frame_dp", {15'h0, dp}, {15'h0, (t < GD) ? 1'b1 : e.dpn[slot]});
      chk("frame_ack", {15'h0, update_ack}, 16'h0000);
      if (an === on_an) low++;
    end
    chk("anode_low_cycles", 16'(low), e.lit ? 16'(4 * (RD - GD)) : 16'd0);
  endtask

  task automatic wait_ack_and_check();
    int n = 0;
    exp_t e;
    while (update_ack !== 1'b1 && n < FR + 4) begin
      @(negedge clk);
      n++;
    end
    chk("ack_seen", {15'h0, update_ack}, 16'h0001);
    chk("ack_at_wrap", 16'(pos % FR), 16'd0);
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL scoreboard empty at ack observed=0 expected=1");
    end else begin
      e = sb.pop_front();
      check_frame(e);
    end
  endtask

  initial begin
    int base;
    exp_t e;

    // reset state
    repeat (3) @(negedge clk);
    chk_blank("reset");
    rst = 1'b0;

    // first frame after release: blank, no ack
    for (int j = 0; j < FR; j++) begin
      @(negedge clk);
      chk_blank("idle_frame");
    end

    // 1234 number, update mid-slot 1
    wait_pos(11);
    e = '{codes: 16'h1234, dpn: 4'hF, lit: 1'b1};
    do_update(16'h1234, 2'd0, 4'h0, 1'b0, e, 1'b0);
    wait_ack_and_check();

    // leading-zero blanking and decimal points
    e = '{codes: 16'hFF70, dpn: 4'b1101, lit: 1'b1};
    do_update(16'h0070, 2'd0, 4'b0010, 1'b1, e, 1'b0);
    wait_ack_and_check();

    e = '{codes: 16'hFFF0, dpn: 4'hF, lit: 1'b1};
    do_update(16'h0000, 2'd0, 4'h0, 1'b1, e, 1'b0);
    wait_ack_and_check();

    e = '{codes: 16'hB0C5, dpn: 4'b0110, lit: 1'b1};
    do_update(16'hB0C5, 2'd0, 4'b1001, 1'b1, e, 1'b0);
    wait_ack_and_check();

    e = '{codes: 16'h0070, dpn: 4'hF, lit: 1'b1};
    do_update(16'h0070, 2'd0, 4'h0, 1'b0, e, 1'b0);
    wait_ack_and_check();

    // Err and Done, dp forced off
    e = '{codes: 16'hFEAA, dpn: 4'hF, lit: 1'b1};
    do_update(16'h1234, 2'd1, 4'hF, 1'b0, e, 1'b0);
    wait_ack_and_check();

    // update on the wrap cycle with nothing pending
    wait_pos(31);
    e = '{codes: 16'hDCBE, dpn: 4'hF, lit: 1'b1};
    do_update(16'h1234, 2'd2, 4'hF, 1'b0, e, 1'b0);
    wait_ack_and_check();

    // latest wins, third update on the wrap cycle itself
    base = ack_cnt;
    wait_pos(3);
    e = '{codes: 16'h1111, dpn: 4'hF, lit: 1'b1};
    do_update(16'h1111, 2'd0, 4'h0, 1'b0, e, 1'b0);
    wait_pos(20);
    e = '{codes: 16'h2222, dpn: 4'hF, lit: 1'b1};
    do_update(16'h2222, 2'd0, 4'h0, 1'b0, e, 1'b1);
    wait_pos(31);
    e = '{codes: 16'h3333, dpn: 4'hF, lit: 1'b1};
    do_update(16'h3333, 2'd0, 4'h0, 1'b0, e, 1'b1);
    wait_ack_and_check();
    chk("single_ack", 16'(ack_cnt - base), 16'd1);

    // reset mid-frame with an update pending: discarded, no ack
    base = ack_cnt;
    wait_pos(9);
    e = '{codes: 16'h5678, dpn: 4'hF, lit: 1'b1};
    do_update(16'h5678, 2'd0, 4'h0, 1'b0, e, 1'b0);
    void'(sb.pop_back());
    wait_pos(19);
    rst = 1'b1;
    @(negedge clk);
    chk_blank("mid_reset");
    rst = 1'b0;
    for (int j = 0; j < FR + 8; j++) begin
      @(negedge clk);
      chk_blank("after_reset");
    end
    chk("no_ack_after_reset", 16'(ack_cnt - base), 16'd0);
    chk("scoreboard_drained", 16'(sb.size()), 16'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
